// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter over 2^M valid/ready channels with a
// registered output stage holding the granted word and its channel index.
module rr_mux_arbiter #(
  parameter int N = 1,
  parameter int M = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [(1<<M)-1:0]     in_valid,
  input  logic [(1<<M)*N-1:0]   in_data,
  output logic [(1<<M)-1:0]     in_ready,
  output logic                  out_valid,
  output logic [N-1:0]          out_data,
  output logic [M-1:0]          out_sel,
  input  logic                  out_ready
);

  localparam int C = 1 << M;

  logic          r_valid;
  logic [N-1:0]  r_data;
  logic [M-1:0]  r_sel;
  logic [M-1:0]  r_ptr;

  logic [M-1:0]  w_grant;
  logic [M-1:0]  w_idx;
  logic          w_found;
  logic          w_any;
  logic          w_load;
  logic          w_accept;

  assign w_any    = |in_valid;
  assign w_load   = !r_valid || out_ready;
  assign w_accept = w_load && w_any;

  // Search from the pointer upward, wrapping, for the first requesting channel.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < C; k++) begin
      w_idx = r_ptr + M'(k);
      if (!w_found && in_valid[w_idx]) begin
        w_grant = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // Accept strobe goes to the granted channel only; held low while in reset.
  always_comb begin
    in_ready = '0;
    if (w_accept && reset_n) begin
      in_ready[w_grant] = 1'b1;
    end
  end

  // Output register and pointer: refill whenever the slot is free or draining.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= in_data[w_grant*N +: N];
        r_sel   <= w_grant;
        r_ptr   <= w_grant + M'(1);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule
